// File: rtl/dcache_way_sram_if.sv
// -----------------------------------------------------------------------------
// std_cache_pkg + dcache_way_sram_if
//
// Purpose:
//   std_cache_pkg supplies the default per-way cache line type (tag, data,
//   valid, dirty) and the matching byte/field enable type (tag, data, vldrty).
//   It is declared here, ahead of the interface, so that every user of the
//   interface sees the package first.
//
//   dcache_way_sram_if bundles the request/response signals of the data cache
//   way SRAM. The requester uses the master modport and the SRAM block uses the
//   slave modport.
//
// Signals:
//   flush_i     : one-cycle pulse, invalidate all lines in all ways
//   req_i       : per-way access request (one bit per way)
//   addr_i      : request address, set index sits directly above the offset
//   wdata_i     : write line, shared by all requested ways
//   we_i        : 1 = write, 0 = read
//   be_i        : write enables, shared by all requested ways
//   rdata_o     : per-way read data, valid one cycle after the request
//   init_done_o : 1 = arrays initialised and accepting requests
// -----------------------------------------------------------------------------
package std_cache_pkg;

   localparam int unsigned DCACHE_TAG_WIDTH  = 44;
   localparam int unsigned DCACHE_LINE_WIDTH = 128;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]  tag;
      logic [DCACHE_LINE_WIDTH-1:0] data;
      logic                         valid;
      logic                         dirty;
   } cache_line_t;

   typedef struct packed {
      logic [DCACHE_TAG_WIDTH-1:0]    tag;
      logic [DCACHE_LINE_WIDTH/8-1:0] data;
      logic                           vldrty;
   } cl_be_t;

endpackage

interface dcache_way_sram_if #(
   parameter int unsigned DCACHE_SET_ASSOC = 8,
   parameter int unsigned ADDR_WIDTH       = 64,
   parameter type         l_data_t         = std_cache_pkg::cache_line_t,
   parameter type         l_be_t           = std_cache_pkg::cl_be_t
);

   logic                                 flush_i;
   logic    [DCACHE_SET_ASSOC-1:0]       req_i;
   logic    [ADDR_WIDTH-1:0]             addr_i;
   l_data_t                              wdata_i;
   logic                                 we_i;
   l_be_t                                be_i;
   l_data_t [DCACHE_SET_ASSOC-1:0]       rdata_o;
   logic                                 init_done_o;

   modport master (
      output flush_i,
      output req_i,
      output addr_i,
      output wdata_i,
      output we_i,
      output be_i,
      input  rdata_o,
      input  init_done_o
   );

   modport slave (
      input  flush_i,
      input  req_i,
      input  addr_i,
      input  wdata_i,
      input  we_i,
      input  be_i,
      output rdata_o,
      output init_done_o
   );

endinterface

// File: rtl/dcache_way_sram.sv
// -----------------------------------------------------------------------------
// dcache_way_sram
//
// Purpose:
//   Tag/data/valid/dirty storage for a set-associative data cache. Each way is
//   an NR_SETS-deep array of lines with one read/write port. After reset (or a
//   flush pulse) an INIT walk clears valid and dirty of one set per cycle in
//   every way; requests are accepted only once the walk has finished (READY).
//   Reads have one cycle of latency; rdata_o of a way that is not accessed
//   holds its previous value.
//
// Ports:
//   clk_i  : clock, all state updates on the rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : dcache_way_sram_if.slave (flush_i, req_i, addr_i, wdata_i, we_i,
//            be_i, rdata_o, init_done_o)
//
// Configuration macro:
//   DCACHE_SRAM_RDW_FWD_EN : when defined, a write returns the merged
//                            post-write line on rdata_o the next cycle; when
//                            undefined it returns the pre-write line.
// -----------------------------------------------------------------------------
module dcache_way_sram #(
   parameter int unsigned NR_SETS          = 256,
   parameter int unsigned DCACHE_SET_ASSOC = 8,
   parameter int unsigned ADDR_WIDTH       = 64,
   parameter int unsigned OFFSET_WIDTH     = 4,
   parameter type         l_data_t         = std_cache_pkg::cache_line_t,
   parameter type         l_be_t           = std_cache_pkg::cl_be_t
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   dcache_way_sram_if.slave   bus
);

   localparam int unsigned IDX_W = $clog2(NR_SETS);

`ifdef DCACHE_SRAM_RDW_FWD_EN
   localparam bit RDW_FWD = 1'b1;
`else
   localparam bit RDW_FWD = 1'b0;
`endif

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   // Apply the write enables of be to old_line, taking new fields from new_line.
   function automatic l_data_t merge_line(input l_data_t old_line,
                                          input l_data_t new_line,
                                          input l_be_t   be);
      l_data_t res;
      res = old_line;
      // Any tag enable bit writes the whole tag.
      if (|be.tag) begin
         res.tag = new_line.tag;
      end else begin
         res.tag = old_line.tag;
      end
      for (int b = 0; b < $bits(be.data); b++) begin
         if (be.data[b]) begin
            res.data[8*b +: 8] = new_line.data[8*b +: 8];
         end else begin
            res.data[8*b +: 8] = old_line.data[8*b +: 8];
         end
      end
      if (be.vldrty) begin
         res.valid = new_line.valid;
         res.dirty = new_line.dirty;
      end else begin
         res.valid = old_line.valid;
         res.dirty = old_line.dirty;
      end
      return res;
   endfunction

   // Control and output registers
   state_e                          state_q, state_d;
   logic [IDX_W-1:0]                cnt_q, cnt_d;
   logic                            init_done_q, init_done_d;
   l_data_t [DCACHE_SET_ASSOC-1:0]  rdata_q, rdata_d;

   // Storage: not reset, validity comes from the INIT walk
   l_data_t                         mem_q [DCACHE_SET_ASSOC][NR_SETS];

   // Single write port per way, shared by the INIT walk and normal writes
   logic [DCACHE_SET_ASSOC-1:0]     mem_we_s;
   logic [IDX_W-1:0]                mem_idx_s;
   l_data_t                         mem_wline_s [DCACHE_SET_ASSOC];

   logic [IDX_W-1:0]                acc_idx_s;
   logic                            unused_addr_s;

   // Set index extraction; bits outside the index field alias to the same set.
   assign acc_idx_s     = bus.addr_i[OFFSET_WIDTH +: IDX_W];
   assign unused_addr_s = ^bus.addr_i;

   // Next-state, counter, write-port and read-data selection.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      mem_we_s  = '0;
      mem_idx_s = acc_idx_s;
      for (int j = 0; j < int'(DCACHE_SET_ASSOC); j++) begin
         mem_wline_s[j] = merge_line(mem_q[j][acc_idx_s], bus.wdata_i, bus.be_i);
      end

      case (state_q)
         INIT: begin
            // Clear valid/dirty of the current set in every way, keep tag/data.
            mem_idx_s = cnt_q;
            mem_we_s  = '1;
            for (int j = 0; j < int'(DCACHE_SET_ASSOC); j++) begin
               mem_wline_s[j]       = mem_q[j][cnt_q];
               mem_wline_s[j].valid = 1'b0;
               mem_wline_s[j].dirty = 1'b0;
            end
            if (bus.flush_i) begin
               // Restart the walk from the first set.
               state_d = INIT;
               cnt_d   = '0;
            end else if (cnt_q == IDX_W'(NR_SETS - 1)) begin
               // Counter wraps to 0 on its own since NR_SETS is a power of two.
               state_d = READY;
               cnt_d   = cnt_q + IDX_W'(1);
            end else begin
               state_d = INIT;
               cnt_d   = cnt_q + IDX_W'(1);
            end
         end
         READY: begin
            if (bus.flush_i) begin
               // Flush wins over any request issued in the same cycle.
               state_d = INIT;
               cnt_d   = '0;
            end else begin
               state_d = READY;
               cnt_d   = cnt_q;
               for (int j = 0; j < int'(DCACHE_SET_ASSOC); j++) begin
                  if (bus.req_i[j]) begin
                     mem_we_s[j] = bus.we_i;
                     if (bus.we_i && RDW_FWD) begin
                        rdata_d[j] = mem_wline_s[j];
                     end else begin
                        rdata_d[j] = mem_q[j][acc_idx_s];
                     end
                  end else begin
                     rdata_d[j] = rdata_q[j];
                  end
               end
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase

      init_done_d = (state_d == READY);
   end

   // State, counter and output registers with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= INIT;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
         rdata_q     <= rdata_d;
      end
   end

   // Way arrays: one write per way per cycle, no reset.
   always_ff @(posedge clk_i) begin
      for (int j = 0; j < int'(DCACHE_SET_ASSOC); j++) begin
         if (mem_we_s[j]) begin
            mem_q[j][mem_idx_s] <= mem_wline_s[j];
         end
      end
   end

   assign bus.rdata_o     = rdata_q;
   assign bus.init_done_o = init_done_q;

endmodule

// File: doc/dcache_way_sram.md
DCACHE_WAY_SRAM -- requirements
Module: dcache_way_sram

Interface
- REQ-001: Parameter NR_SETS, default 256: sets per way; power of two, at least 2.
- REQ-002: Parameter DCACHE_SET_ASSOC, default 8: number of ways.
- REQ-003: Parameter ADDR_WIDTH, default 64: request address width.
- REQ-004: Parameter OFFSET_WIDTH, default 4: line-offset bits below the set index.
- REQ-005: Parameter l_data_t, default std_cache_pkg::cache_line_t: per-way line with fields tag, data, valid, dirty.
- REQ-006: Parameter l_be_t, default std_cache_pkg::cl_be_t: enables with fields tag (bit vector), data (one bit per data byte), vldrty (one bit).
- REQ-007: clk_i  input  1: single clock; all state is updated on its rising edge.
- REQ-008: rst_ni  input  1: reset, asynchronous and active-low.
- REQ-009: flush_i  input  1: one-cycle pulse that invalidates all lines in all ways.
- REQ-010: req_i  input  DCACHE_SET_ASSOC: per-way access request.
- REQ-011: addr_i  input  ADDR_WIDTH: set index = addr_i[OFFSET_WIDTH+log2(NR_SETS)-1:OFFSET_WIDTH].
- REQ-012: wdata_i  input  l_data_t: write line, shared by all requested ways.
- REQ-013: we_i  input  1: 1 = write, 0 = read.
- REQ-014: be_i  input  l_be_t: write enables, shared by all requested ways.
- REQ-015: rdata_o  output  DCACHE_SET_ASSOC x l_data_t: per-way read data, one cycle after the request.
- REQ-016: init_done_o  output  1: 1 = arrays initialised and accepting requests.

Function
- REQ-017: The FSM SHALL have two states, INIT and READY; reset enters INIT with the set counter at 0.
- REQ-018: In INIT, each cycle SHALL clear valid and dirty of set[counter] in every way and increment the counter; tag and data are not modified.
- REQ-019: After the cycle that clears set NR_SETS-1, the FSM SHALL move to READY and the counter SHALL wrap to 0; the walk takes exactly NR_SETS cycles.
- REQ-020: init_done_o SHALL be 1 only in READY; the value is registered.
- REQ-021: A flush_i pulse in READY SHALL move the FSM to INIT with the counter at 0.
- REQ-022: A flush_i pulse in INIT SHALL restart the walk at set 0.
- REQ-023: In INIT, req_i SHALL be ignored, the arrays SHALL NOT be written, and rdata_o SHALL hold its value.
- REQ-024: If flush_i and req_i are both asserted in the same READY cycle, flush SHALL win and the request SHALL be dropped.
- REQ-025: Read: in READY with req_i[j]=1 and we_i=0, rdata_o[j] SHALL present way j of the indexed set on the next cycle (one-cycle latency).
- REQ-026: Write: in READY with req_i[j]=1 and we_i=1:
  - tag SHALL be written if any bit of be_i.tag is set;
  - data byte b SHALL be written if be_i.data[b] is set;
  - valid and dirty SHALL be written if be_i.vldrty is set.
- REQ-027: The rdata_o[j] of a way that is not requested SHALL hold its previous value.
- REQ-028: Several ways MAY be requested in the same cycle; each way is independent and none takes priority.
- REQ-029: An address with bits outside the index field differing SHALL alias to the same set; there is no range check.

Reset
- REQ-030: On rst_ni low, asynchronously: FSM = INIT, counter = 0, rdata_o = all zero, init_done_o = 0.
- REQ-031: Array contents are not reset directly; validity is established by the INIT walk.
- REQ-032: Reset asserted mid-walk or mid-access SHALL abort the operation, with no partial write guaranteed, and the walk SHALL restart from set 0.

Configuration
- REQ-033: With DCACHE_SRAM_RDW_FWD_EN defined, the rdata_o[j] after a write SHALL equal the merged post-write line (new data forwarded).
- REQ-034: Without DCACHE_SRAM_RDW_FWD_EN, the rdata_o[j] after a write SHALL equal the pre-write line contents.

Verification
- REQ-035: Release reset -> init_done_o = 0 for exactly 256 cycles, then 1; a read of any set/way -> valid = 0, dirty = 0.
- REQ-036: Write way 3, set 5, with all enables set, tag = 0x1234, data = 0xA5 repeated, valid = 1; then read set 5 with req_i = 0xFF -> rdata_o[3] = tag 0x1234, valid 1, data 0xA5 repeated; every other way has valid = 0.
- REQ-037: Write with be_i.data = 0x0001 only, data byte 0 = 0x77, over 0xA5 -> byte 0 = 0x77, bytes 1..15 = 0xA5, tag and valid unchanged.
- REQ-038: Write way 0 -> next-cycle rdata_o[0] is the new line with the macro defined and the old line without it.
- REQ-039: Pulse flush_i together with a write to set 7 -> the write is dropped, init_done_o is low for 256 cycles, and a later read of set 7 returns valid = 0.
- REQ-040: Assert rst_ni low at walk cycle 100 -> rdata_o = 0 immediately; after release, init_done_o rises exactly 256 cycles later.
